// File: rtl/stereo_rgb_line_arbiter.sv
// Line-granular round-robin arbiter that merges left/right RGB AXI4-Stream inputs into one tagged stream.
// Optional line-length checker enabled by defining STEREO_ARB_LINE_CHECK_EN.
module stereo_rgb_line_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 4,
  parameter int LINE_BEATS = 480
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [DATA_WIDTH*PPC*3-1:0] s_axis_left_tdata,
  input  logic                        s_axis_left_tvalid,
  input  logic                        s_axis_left_tuser,
  input  logic                        s_axis_left_tlast,
  output logic                        s_axis_left_tready,
  input  logic [DATA_WIDTH*PPC*3-1:0] s_axis_right_tdata,
  input  logic                        s_axis_right_tvalid,
  input  logic                        s_axis_right_tuser,
  input  logic                        s_axis_right_tlast,
  output logic                        s_axis_right_tready,
  output logic [DATA_WIDTH*PPC*3-1:0] m_axis_rgb_tdata,
  output logic                        m_axis_rgb_tvalid,
  output logic                        m_axis_rgb_tuser,
  output logic                        m_axis_rgb_tlast,
  output logic                        m_axis_rgb_tid,
  input  logic                        m_axis_rgb_tready,
  output logic                        err_line_len
);

  localparam int TW = DATA_WIDTH * PPC * 3;

  typedef enum logic [1:0] {IDLE, GRANT_L, GRANT_R} state_t;

  state_t state;
  logic   last_grant;   // 0 = left, 1 = right
  logic   out_free;
  logic   acc_l;
  logic   acc_r;
  logic   acc_p0;
  logic   sel_r_p0;
  logic   [TW-1:0] data_p0;
  logic   user_p0;
  logic   last_p0;

  // Ready only toward the granted channel, and only when the output register can take a beat
  assign out_free            = !m_axis_rgb_tvalid || m_axis_rgb_tready;
  assign s_axis_left_tready  = (state == GRANT_L) && out_free;
  assign s_axis_right_tready = (state == GRANT_R) && out_free;

  assign acc_l    = s_axis_left_tvalid  && s_axis_left_tready;
  assign acc_r    = s_axis_right_tvalid && s_axis_right_tready;
  assign acc_p0   = acc_l || acc_r;
  assign sel_r_p0 = acc_r;
  assign data_p0  = sel_r_p0 ? s_axis_right_tdata : s_axis_left_tdata;
  assign user_p0  = sel_r_p0 ? s_axis_right_tuser : s_axis_left_tuser;
  assign last_p0  = sel_r_p0 ? s_axis_right_tlast : s_axis_left_tlast;

  // ---- stage p0 -> p1: output register and grant FSM ----
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      m_axis_rgb_tdata  <= '0;
      m_axis_rgb_tvalid <= 1'b0;
      m_axis_rgb_tuser  <= 1'b0;
      m_axis_rgb_tlast  <= 1'b0;
      m_axis_rgb_tid    <= 1'b0;
    end else begin
      if (acc_p0) begin
        m_axis_rgb_tdata  <= data_p0;
        m_axis_rgb_tuser  <= user_p0;
        m_axis_rgb_tlast  <= last_p0;
        m_axis_rgb_tid    <= sel_r_p0;
        m_axis_rgb_tvalid <= 1'b1;
      end else if (m_axis_rgb_tready) begin
        m_axis_rgb_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s_axis_left_tvalid && s_axis_right_tvalid)
            state <= last_grant ? GRANT_L : GRANT_R;
          else if (s_axis_left_tvalid)
            state <= GRANT_L;
          else if (s_axis_right_tvalid)
            state <= GRANT_R;
        end
        GRANT_L: begin
          if (acc_l && s_axis_left_tlast) begin
            last_grant <= 1'b0;
            state      <= s_axis_right_tvalid ? GRANT_R : IDLE;
          end
        end
        GRANT_R: begin
          if (acc_r && s_axis_right_tlast) begin
            last_grant <= 1'b1;
            state      <= s_axis_left_tvalid ? GRANT_L : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STEREO_ARB_LINE_CHECK_EN
  localparam int CW = $clog2(LINE_BEATS + 1);
  localparam logic [CW:0] LINE_LEN = (CW + 1)'(LINE_BEATS);

  logic [CW-1:0] beat_cnt;
  logic [CW:0]   cnt_next;
  logic          len_hit;

  assign cnt_next = {1'b0, beat_cnt} + (CW + 1)'(1);
  assign len_hit  = (cnt_next == LINE_LEN);

  // Count restarts for every new grant; a mismatch between tlast and the expected length is sticky
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt     <= '0;
      err_line_len <= 1'b0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
    end else if (acc_p0) begin
      beat_cnt <= last_p0 ? '0 : cnt_next[CW-1:0];
      if (last_p0 != len_hit)
        err_line_len <= 1'b1;
    end
  end
`else
  assign err_line_len = 1'b0 & (LINE_BEATS > 0);
`endif

endmodule

// File: doc/stereo_rgb_line_arbiter.md
Name: stereo_rgb_line_arbiter

Overview:
Shares one RGB-to-grayscale conversion pipeline between the left and right camera RGB AXI4-Stream inputs of the stereovision core. Arbitration is round-robin at line granularity: a grant is held from the first beat of a line until its tlast beat is accepted. The output feeds the converter's RGB slave port, with a channel tag so that downstream logic can demultiplex the gray lines back to left/right.

Parameters:
DATA_WIDTH, 8, pixel component width in bits
PPC, 4, pixels per clock; tdata width is DATA_WIDTH*PPC*3
LINE_BEATS, 480, expected beats per line; used only when the optional feature is enabled

Ports:
aclk  in  1  clock; all logic is on the rising edge
areset  in  1  asynchronous, active-high reset
s_axis_left_tdata  in  DATA_WIDTH*PPC*3  left RGB pixels
s_axis_left_tvalid  in  1  left valid
s_axis_left_tuser  in  1  left start of frame
s_axis_left_tlast  in  1  left end of line
s_axis_left_tready  out  1  left ready
s_axis_right_tdata  in  DATA_WIDTH*PPC*3  right RGB pixels
s_axis_right_tvalid  in  1  right valid
s_axis_right_tuser  in  1  right start of frame
s_axis_right_tlast  in  1  right end of line
s_axis_right_tready  out  1  right ready
m_axis_rgb_tdata  out  DATA_WIDTH*PPC*3  pixels to the converter
m_axis_rgb_tvalid  out  1  output valid
m_axis_rgb_tuser  out  1  forwarded start of frame
m_axis_rgb_tlast  out  1  forwarded end of line
m_axis_rgb_tid  out  1  source channel: 0 = left, 1 = right
m_axis_rgb_tready  in  1  converter ready
err_line_len  out  1  sticky line-length error (optional feature)

Behaviour:
- Reset values (asynchronous, while areset = 1):
  - state = IDLE; last_grant = RIGHT, so left wins the first tie.
  - All m_axis_rgb_* outputs = 0.
  - Both s_*_tready = 0.
  - err_line_len = 0.
- States: IDLE, GRANT_L, GRANT_R.
- IDLE:
  - If both tvalid are high, go to the channel that is not last_grant.
  - If only one tvalid is high, go to that channel.
  - If neither is high, stay in IDLE.
  - In IDLE both treadys are 0. The grant decision takes one cycle.
- GRANT_x:
  - s_x_tready = !m_axis_rgb_tvalid | m_axis_rgb_tready (a single registered output stage).
  - The other channel's tready = 0.
- Beat accept means s_x_tvalid & s_x_tready. On accept:
  - Register tdata, tuser and tlast into the output stage.
  - Set m_axis_rgb_tid = x and m_axis_rgb_tvalid = 1.
- Output stage:
  - When m_axis_rgb_tready = 1 and no beat is accepted, m_axis_rgb_tvalid clears to 0.
  - While m_axis_rgb_tvalid = 1 and m_axis_rgb_tready = 0, all m_axis_rgb_* signals hold stable.
- Latency: one cycle from input accept to m_axis_rgb_tvalid. Throughput is one beat per cycle within a line.
- End of line (accepted beat with tlast = 1):
  - last_grant = x.
  - If the other channel's tvalid is high in the same cycle, go directly to GRANT_other with no bubble; otherwise go to IDLE.
- tuser is forwarded unmodified. It does not affect arbitration.
- Mid-line behaviour: a grant is never revoked. The other channel waits even if the granted channel deasserts tvalid.
- Simultaneous tlast accept and m_axis_rgb_tready: the output register is updated, and the new grant takes effect the next cycle.
- Reset mid-line: the in-flight output beat is dropped, treadys go to 0 immediately, and the next grant is left-first.

Optional Feature:
STEREO_ARB_LINE_CHECK_EN
- Defined:
  - A counter of width $clog2(LINE_BEATS+1) counts accepted beats of the granted line and is cleared on each grant.
  - err_line_len is set (sticky until areset) when either:
    - tlast is accepted with count+1 != LINE_BEATS, or
    - count+1 == LINE_BEATS is reached on a beat without tlast.
  - Data flow is unaffected.
- Not defined: no counter is built and err_line_len is tied to 0.

Test Plan:
- Both inputs valid after reset, LINE_BEATS = 4, lines of 4 beats, m_tready = 1 → output lines alternate L,R,L,R with tid 0,1,0,1 and no idle cycle between lines.
- Only right valid → GRANT_R after one IDLE cycle; first m_tvalid appears 2 cycles after s_right_tvalid rises; left tready stays 0.
- m_tready held low for 3 cycles mid-line → m_tdata, tuser, tlast and tid stay stable; s_left_tready = 0 during the stall; no beat is lost or duplicated (compare against a scoreboard).
- Left line in progress while right asserts valid; left deasserts valid for 5 cycles → right tready stays 0 until left tlast is accepted.
- areset pulse at beat 2 of a right line → m_tvalid = 0 within the reset cycle; after release with both valid, left is granted first.
- Macro defined, LINE_BEATS = 4, left line of 3 beats with tlast → err_line_len = 1 the cycle after the tlast accept and stays 1; with the macro undefined, the same stimulus leaves err_line_len = 0.
